// File: rtl/square_generator.sv
// Registered 2-bit squarer with a saturating sum-of-squares accumulator and
// a saturating sample counter, both clearable synchronously.
module square_generator #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             in_valid,
    input  logic             clr,
    output logic [3:0]       D,
    output logic             out_valid,
    output logic [ACC_W-1:0] sum_sq,
    output logic [ACC_W-1:0] count,
    output logic             sat
);

    // Handshake: in_valid has no back-pressure; every cycle it is high the
    // sample is accepted, and out_valid pulses exactly one cycle later.
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic [3:0]       d_q, d_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] sum_sq_q, sum_sq_d;
    logic [ACC_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    logic [3:0]     sq;
    logic [ACC_W:0] sum_ext;
    logic [ACC_W:0] count_ext;

    always_comb begin
        sq          = {A & B, A & ~B, 1'b0, B};
        // One extra carry bit reveals when an add would pass the maximum.
        sum_ext     = {1'b0, sum_sq_q} + {{(ACC_W-3){1'b0}}, sq};
        count_ext   = {1'b0, count_q} + {{ACC_W{1'b0}}, 1'b1};

        d_d         = d_q;
        out_valid_d = in_valid;
        sum_sq_d    = sum_sq_q;
        count_d     = count_q;
        sat_d       = sat_q;

        if (in_valid) begin
            d_d = sq;
        end

        if (clr) begin
            sum_sq_d = in_valid ? {{(ACC_W-4){1'b0}}, sq} : '0;
            count_d  = in_valid ? {{(ACC_W-1){1'b0}}, 1'b1} : '0;
            sat_d    = 1'b0;
        end else if (in_valid) begin
            sum_sq_d = sum_ext[ACC_W] ? ACC_MAX : sum_ext[ACC_W-1:0];
            count_d  = count_ext[ACC_W] ? ACC_MAX : count_ext[ACC_W-1:0];
            sat_d    = sat_q | sum_ext[ACC_W] | count_ext[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= 4'b0000;
            out_valid_q <= 1'b0;
            sum_sq_q    <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            sum_sq_q    <= sum_sq_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
        end
    end

    assign D         = d_q;
    assign out_valid = out_valid_q;
    assign sum_sq    = sum_sq_q;
    assign count     = count_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_square_generator.sv
// Directed bench for square_generator: stimulus pushes hand-computed results
// into an expected queue, a negedge monitor pops and compares on out_valid.
module tb_square_generator;

    localparam int ACC_W = 8;
    localparam int EW    = 4 + ACC_W + ACC_W + 1;

    logic             clk;
    logic             rst_n;
    logic             A, B, in_valid, clr;
    logic [3:0]       D;
    logic             out_valid;
    logic [ACC_W-1:0] sum_sq, count;
    logic             sat;

    logic [EW-1:0] exp_q[$];
    int checks_total;
    int checks_passed;

    square_generator #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
        .clr(clr), .D(D), .out_valid(out_valid), .sum_sq(sum_sq),
        .count(count), .sat(sat)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks_total++;
        if (act === req) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Driver tasks: called at posedge+1, return at the following posedge+1.
    task automatic drive(input logic [1:0] n, input logic c, input logic [3:0] ed,
                         input logic [ACC_W-1:0] es, input logic [ACC_W-1:0] ec,
                         input logic esat);
        A = n[1]; B = n[0]; in_valid = 1'b1; clr = c;
        exp_q.push_back({ed, es, ec, esat});
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input logic [3:0] ed, input logic [ACC_W-1:0] es,
                              input logic [ACC_W-1:0] ec);
        A = $urandom_range(0, 1); B = $urandom_range(0, 1);
        in_valid = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        check("hold_out_valid", {31'd0, out_valid}, 32'd0);
        check("hold_d", {28'd0, D}, {28'd0, ed});
        check("hold_sum", {24'd0, sum_sq}, {24'd0, es});
        check("hold_count", {24'd0, count}, {24'd0, ec});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("d", {28'd0, D}, {28'd0, e[EW-1 -: 4]});
                check("sum_sq", {24'd0, sum_sq}, {24'd0, e[EW-5 -: ACC_W]});
                check("count", {24'd0, count}, {24'd0, e[ACC_W:1]});
                check("sat", {31'd0, sat}, {31'd0, e[0]});
            end
        end
    end

    initial begin
        checks_total = 0; checks_passed = 0;
        rst_n = 1'b0; A = 1'b1; B = 1'b1; in_valid = 1'b1; clr = 1'b0;
        #3;
        check("rst_d", {28'd0, D}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        // Reset must hold even across edges with valid input present.
        #20;
        check("rst_hold_d", {28'd0, D}, 32'd0);
        check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hold_sum", {24'd0, sum_sq}, 32'd0);
        check("rst_hold_count", {24'd0, count}, 32'd0);
        check("rst_hold_sat", {31'd0, sat}, 32'd0);
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Exhaustive table
        drive(2'd0, 1'b0, 4'b0000, 8'd0,  8'd1, 1'b0);
        drive(2'd1, 1'b0, 4'b0001, 8'd1,  8'd2, 1'b0);
        drive(2'd2, 1'b0, 4'b0100, 8'd5,  8'd3, 1'b0);
        drive(2'd3, 1'b0, 4'b1001, 8'd14, 8'd4, 1'b0);
        drive(2'd2, 1'b0, 4'b0100, 8'd18, 8'd5, 1'b0);

        // Accumulation from a fresh clear (first sample rides the clear)
        drive(2'd1, 1'b1, 4'b0001, 8'd1,  8'd1, 1'b0);
        drive(2'd2, 1'b0, 4'b0100, 8'd5,  8'd2, 1'b0);
        drive(2'd3, 1'b0, 4'b1001, 8'd14, 8'd3, 1'b0);

        // Hold with toggling operands
        for (int i = 0; i < 3; i++) idle_check(4'b1001, 8'd14, 8'd3);

        // Clear priority over accumulation
        drive(2'd2, 1'b1, 4'b0100, 8'd4, 8'd1, 1'b0);

        // Saturation: 29 samples of 9 -> 252 after 28, clamps to 255 on 29th
        drive(2'd3, 1'b1, 4'b1001, 8'd9, 8'd1, 1'b0);
        for (int k = 2; k <= 29; k++) begin
            int s;
            s = 9 * k;
            drive(2'd3, 1'b0, 4'b1001, (s > 255) ? 8'd255 : 8'(s), 8'(k), s > 255);
        end
        idle_check(4'b1001, 8'd255, 8'd29);
        check("sat_sticky", {31'd0, sat}, 32'd1);

        // Async reset mid-stream, between clock edges
        drive(2'd1, 1'b0, 4'b0001, 8'd255, 8'd30, 1'b1);
        in_valid = 1'b0;
        #5;
        check("pre_async_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_d", {28'd0, D}, 32'd0);
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_sum", {24'd0, sum_sq}, 32'd0);
        check("async_count", {24'd0, count}, 32'd0);
        check("async_sat", {31'd0, sat}, 32'd0);
        #20;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
